// File: rtl/reset_sequencer_if.sv
// Reset-sequencer signal bundle: MMCM lock in, reset requests and status out.
// retry_cnt exists only when RST_SEQ_RETRY_CNT_EN is defined.
interface reset_sequencer_if;
   logic       mmcm_locked;
   logic       mmcm_rst;
   logic       periph_rst;
   logic       core_rst;
   logic       ready;
   logic       lock_timeout;
`ifdef RST_SEQ_RETRY_CNT_EN
   logic [7:0] retry_cnt;

   modport master (input mmcm_locked,
                   output mmcm_rst, periph_rst, core_rst, ready, lock_timeout, retry_cnt);
   modport slave  (output mmcm_locked,
                   input mmcm_rst, periph_rst, core_rst, ready, lock_timeout, retry_cnt);
`else
   modport master (input mmcm_locked,
                   output mmcm_rst, periph_rst, core_rst, ready, lock_timeout);
   modport slave  (output mmcm_locked,
                   input mmcm_rst, periph_rst, core_rst, ready, lock_timeout);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Power-up / lock-loss reset sequencer in the free-running clk domain.
// Optional lock-timeout counter output enabled by RST_SEQ_RETRY_CNT_EN.
module reset_sequencer #(
   parameter int MMCM_RST_CYCLES       = 16,
   parameter int LOCK_TIMEOUT          = 65535,
   parameter int LOCK_STABLE_CYCLES    = 256,
   parameter int PERIPH_TO_CORE_CYCLES = 32
) (
   input  logic               clk,
   input  logic               async_reset,
   reset_sequencer_if.master  bus
);
   localparam int MAX_AB  = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD  = (LOCK_STABLE_CYCLES > PERIPH_TO_CORE_CYCLES) ?
                            LOCK_STABLE_CYCLES : PERIPH_TO_CORE_CYCLES;
   localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_ALL) + 1;

   typedef enum logic [2:0] {
      S_MMCM_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_REL_PERIPH,
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lock_meta_q, lock_meta_d;
   logic             lock_s_q, lock_s_d;
   logic             mmcm_rst_q, mmcm_rst_d;
   logic             periph_rst_q, periph_rst_d;
   logic             core_rst_q, core_rst_d;
   logic             ready_q, ready_d;
   logic             lock_timeout_q, lock_timeout_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q + 1'b1;
      lock_timeout_d = 1'b0;
      lock_meta_d    = bus.mmcm_locked;
      lock_s_d       = lock_meta_q;

      unique case (state_q)
         S_MMCM_RST: begin
            if (cnt_q == CNT_W'(MMCM_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = S_STABLE;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d        = S_MMCM_RST;
               lock_timeout_d = 1'b1;
            end
         end
         S_STABLE: begin
            // A dropout here only restarts the lock wait, not the MMCM reset.
            if (!lock_s_q) state_d = S_WAIT_LOCK;
            else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = S_REL_PERIPH;
         end
         S_REL_PERIPH: begin
            if (!lock_s_q) state_d = S_MMCM_RST;
            else if (cnt_q == CNT_W'(PERIPH_TO_CORE_CYCLES - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lock_s_q) state_d = S_MMCM_RST;
         end
         default: state_d = S_MMCM_RST;
      endcase

      if (state_d != state_q) cnt_d = '0;

      // Outputs decode the next state so they switch on the transition edge.
      mmcm_rst_d   = (state_d == S_MMCM_RST);
      periph_rst_d = (state_d inside {S_MMCM_RST, S_WAIT_LOCK, S_STABLE});
      core_rst_d   = (state_d != S_RUN);
      ready_d      = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state_q        <= S_MMCM_RST;
         cnt_q          <= '0;
         lock_meta_q    <= 1'b0;
         lock_s_q       <= 1'b0;
         mmcm_rst_q     <= 1'b1;
         periph_rst_q   <= 1'b1;
         core_rst_q     <= 1'b1;
         ready_q        <= 1'b0;
         lock_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lock_meta_q    <= lock_meta_d;
         lock_s_q       <= lock_s_d;
         mmcm_rst_q     <= mmcm_rst_d;
         periph_rst_q   <= periph_rst_d;
         core_rst_q     <= core_rst_d;
         ready_q        <= ready_d;
         lock_timeout_q <= lock_timeout_d;
      end
   end

   assign bus.mmcm_rst     = mmcm_rst_q;
   assign bus.periph_rst   = periph_rst_q;
   assign bus.core_rst     = core_rst_q;
   assign bus.ready        = ready_q;
   assign bus.lock_timeout = lock_timeout_q;

`ifdef RST_SEQ_RETRY_CNT_EN
   logic [7:0] retry_cnt_q, retry_cnt_d;

   // Saturating; only async_reset clears it so it survives re-sequencing.
   always_comb begin
      retry_cnt_d = retry_cnt_q;
      if (lock_timeout_d && (retry_cnt_q != 8'hFF)) retry_cnt_d = retry_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) retry_cnt_q <= 8'd0;
      else             retry_cnt_q <= retry_cnt_d;
   end

   assign bus.retry_cnt = retry_cnt_q;
`endif
endmodule
